// File: rtl/exmem_pkg.sv
// exmem_pkg: shared constants for the EX->MEM pipeline stage.
//   CTRL_W         width of the control bundle
//   CTRL_*         bit positions inside the control bundle
//   ST_*           occupancy state encoding (value equals entry count)
//   payload_width  packed width of one buffered entry (without valid)
package exmem_pkg;

    localparam int unsigned CTRL_W = 5;

    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_R0WRITE   = 1;
    localparam int unsigned CTRL_MEMREAD   = 2;
    localparam int unsigned CTRL_MEMWRITE  = 3;
    localparam int unsigned CTRL_MEMSOURCE = 4;

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Entry layout: {ctrl, rd, alu, store, r0}.
    function automatic int unsigned payload_width(input int unsigned dw, input int unsigned aw);
        return CTRL_W + aw + 3 * dw;
    endfunction

endpackage

// File: rtl/exmem_pipe_entry_reg.sv
// pipe_entry_reg: one buffered pipeline entry, payload plus valid bit.
//   clk, reset  clock and synchronous active-high reset (clears valid and payload)
//   clear_i     drop the entry (valid := 0, payload held)
//   load_i      capture data_i and mark valid; clear_i has priority
//   data_i      payload to capture
//   valid_o     entry holds a live instruction
//   data_o      stored payload
module pipe_entry_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/exmem_pipe_stage.sv
// exmem_pipe_stage: EX->MEM stage register with valid/ready handshake and a
// two-entry skid buffer so MEM stalls never reach EX combinationally.
//   clk, reset            clock, synchronous active-high reset (clears everything)
//   flush                 kill all buffered entries next cycle
//   in_valid/in_ready     EX-side handshake; in_ready is a register
//   in_ctrl/rd/alu/store/r0  instruction fields from EX
//   out_valid/out_ready   MEM-side handshake
//   out_ctrl/rd/alu/store/r0 head entry fields; out_ctrl is zero on bubbles
//   occupancy             number of buffered entries (0..2)
module exmem_pipe_stage
    import exmem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_store,
    input  logic [DATA_W-1:0] in_r0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store,
    output logic [DATA_W-1:0] out_r0,
    output logic [1:0]        occupancy
);

    localparam int unsigned PW = payload_width(DATA_W, REG_AW);

    logic [1:0]    state_q, state_d;
    logic          in_ready_q;

    logic          main_valid, skid_valid;
    logic [PW-1:0] main_data, skid_data, in_payload, main_next;
    logic          main_load, main_clear, main_from_skid;
    logic          skid_load, skid_clear;
    logic          accept, pop;

    assign in_payload = {in_ctrl, in_rd, in_alu, in_store, in_r0};
    assign accept     = in_valid & in_ready_q;
    assign pop        = main_valid & out_ready;
    assign main_next  = main_from_skid ? skid_data : in_payload;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            // Flush wins over accept and pop; a pop this cycle is still MEM's.
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can occur.
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    pipe_entry_reg #(
        .W (PW)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear_i (main_clear),
        .load_i  (main_load),
        .data_i  (main_next),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    pipe_entry_reg #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .data_i  (in_payload),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    logic [CTRL_W-1:0] main_ctrl;

    assign {main_ctrl, out_rd, out_alu, out_store, out_r0} = main_data;

    assign out_valid = main_valid;
    // Bubble masking: no write/read enable reaches MEM without a valid entry.
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign in_ready  = in_ready_q;
    assign occupancy = state_q;

    // Skid validity is implied by the state; kept only for visibility.
    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Testbench for exmem_pipe_stage: directed scenarios plus a randomized run,
// all checked against a queue-based FIFO model of the stage.
module tb_exmem_pipe_stage;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic [15:0] st;
        logic [15:0] r0;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_ctrl = '0;
    logic [3:0]  in_rd = '0;
    logic [15:0] in_alu = '0;
    logic [15:0] in_store = '0;
    logic [15:0] in_r0 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_ctrl;
    logic [3:0]  out_rd;
    logic [15:0] out_alu;
    logic [15:0] out_store;
    logic [15:0] out_r0;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    bit   last_was_reset;

    always #5 clk = ~clk;

    exmem_pipe_stage #(
        .DATA_W (16),
        .REG_AW (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_alu    (in_alu),
        .in_store  (in_store),
        .in_r0     (in_r0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_alu   (out_alu),
        .out_store (out_store),
        .out_r0    (out_r0),
        .occupancy (occupancy)
    );

    // Model: a FIFO of at most two entries; ready whenever it has room.
    task automatic step();
        bit   acc;
        ent_t e;
        @(posedge clk);
        acc = in_valid && (q.size() < 2);
        e   = '{ctrl: in_ctrl, rd: in_rd, alu: in_alu, st: in_store, r0: in_r0};
        last_was_reset = reset;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] c, input logic [15:0] a);
        in_valid = v;
        in_ctrl  = c;
        in_alu   = a;
        in_rd    = 4'($urandom);
        in_store = 16'($urandom);
        in_r0    = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset_hs: valid=%b ready=%b occ=%0d, want 0 1 0",
                     out_valid, in_ready, occupancy);
        end
        checks++;
        if ({out_ctrl, out_rd, out_alu, out_store, out_r0} !== '0) begin
            errors++;
            $display("FAIL reset_data: ctrl=%h rd=%h alu=%h st=%h r0=%h, want all 0",
                     out_ctrl, out_rd, out_alu, out_store, out_r0);
        end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'b00001, 16'(i));
            step();
            checks++;
            if (out_valid !== 1'b1 || out_alu !== 16'(i) || out_ctrl !== 5'b00001
                || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b alu=%h ctrl=%b occ=%0d, want 1 %h 00001 1",
                         i, out_valid, out_alu, out_ctrl, occupancy, 16'(i));
            end
        end
        drive(1'b0, 5'b0, 16'h0);
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] seq[3];
        seq[0] = 16'hAAAA;
        seq[1] = 16'hBBBB;
        seq[2] = 16'hCCCC;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b00100, seq[i]);
            step();
        end
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu !== 16'hAAAA) begin
            errors++;
            $display("FAIL bp_full: occ=%0d ready=%b alu=%h, want 2 0 aaaa",
                     occupancy, in_ready, out_alu);
        end
        // 0xCCCC is still offered; release MEM.
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 16'hBBBB || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: valid=%b alu=%h ready=%b, want 1 bbbb 1",
                     out_valid, out_alu, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 16'hCCCC || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL bp_third: valid=%b alu=%h occ=%0d, want 1 cccc 1",
                     out_valid, out_alu, occupancy);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 5'b00001, 16'h1111);
        step();
        drive(1'b1, 5'b00001, 16'h2222);
        step();
        drive(1'b1, 5'b01000, 16'h1234);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 5'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: valid=%b ctrl=%b occ=%0d ready=%b, want 0 00000 0 1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost_%0d: valid=%b alu=%h, want valid 0", i, out_valid,
                         out_alu);
            end
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        drive(1'b1, 5'b11111, 16'h00FF);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 16'h00FF || out_ctrl !== 5'b11111) begin
            errors++;
            $display("FAIL bubble_live: valid=%b alu=%h ctrl=%b, want 1 00ff 11111",
                     out_valid, out_alu, out_ctrl);
        end
        drive(1'b0, 5'b11111, 16'hDEAD);
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 5'b00000) begin
            errors++;
            $display("FAIL bubble_mask: valid=%b ctrl=%b, want 0 00000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_reset_priority();
        out_ready = 1'b0;
        drive(1'b1, 5'b00011, 16'h5555);
        step();
        drive(1'b1, 5'b00011, 16'h6666);
        step();
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        checks++;
        if ({out_valid, out_ctrl, out_rd, out_alu, out_store, out_r0} !== '0
            || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rst_prio: valid=%b ctrl=%b alu=%h ready=%b occ=%0d, want 0 0 0 1 0",
                     out_valid, out_ctrl, out_alu, in_ready, occupancy);
        end
        out_ready = 1'b1;
        drive(1'b1, 5'b00001, 16'h0042);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_alu !== 16'h0042) begin
            errors++;
            $display("FAIL rst_prio_push: valid=%b alu=%h, want 1 0042", out_valid, out_alu);
        end
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = 5'($urandom);
            in_rd     = 4'($urandom);
            in_alu    = 16'($urandom);
            in_store  = 16'($urandom);
            in_r0     = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 90) == 0);
            step();
            checks++;
            if (occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2)
                || out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rand_hs_%0d: occ=%0d ready=%b valid=%b, want occ %0d",
                         n, occupancy, in_ready, out_valid, q.size());
            end
            checks++;
            if (q.size() > 0) begin
                h = q[0];
                if ({out_ctrl, out_rd, out_alu, out_store, out_r0} !== h) begin
                    errors++;
                    $display("FAIL rand_head_%0d: got %h, want %h", n,
                             {out_ctrl, out_rd, out_alu, out_store, out_r0}, h);
                end
            end else if (out_ctrl !== 5'b0 || (last_was_reset && out_alu !== 16'h0)) begin
                errors++;
                $display("FAIL rand_bubble_%0d: ctrl=%b alu=%h, want ctrl 0", n, out_ctrl,
                         out_alu);
            end
        end
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exmem_pipe_stage.md
Name: exmem_pipe_stage

Overview:
Parametrised EX->MEM pipeline stage register, successor to the fixed 16-bit EX/MEM buffer. Adds a valid/ready handshake with a 2-entry skid buffer, so MEM-side stalls do not combinationally reach EX. Adds a synchronous flush that kills in-flight instructions, and bubble masking of control bits. Sits between the ALU stage and the data-memory stage of the 16-bit core.

Parameters:
DATA_W, 16, width of ALU result, store data and R0 data fields
REG_AW, 4, width of destination register address
CTRL_W, 5, width of control bundle (fixed by package; bit map below)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
flush  in  1  synchronous kill of all buffered entries (branch/exception)
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept; registered, depends only on state
in_ctrl  in  CTRL_W  {memSource,memWrite,memRead,r0Write,regWrite} (bit4..bit0)
in_rd  in  REG_AW  destination register address
in_alu  in  DATA_W  ALU result / memory address
in_store  in  DATA_W  store data
in_r0  in  DATA_W  R0 write data
out_valid  out  1  head entry valid toward MEM
out_ready  in  1  MEM accepts head entry this cycle
out_ctrl  out  CTRL_W  head control; forced 0 when out_valid=0
out_rd  out  REG_AW  head destination address
out_alu, out_store, out_r0  out  DATA_W each  head data fields
occupancy  out  2  number of buffered entries (0..2)

Behaviour:
- Storage: main entry (drives outputs) plus skid entry, each {valid, ctrl, rd, alu, store, r0}.
- States: EMPTY (0 entries), ONE (main only), FULL (main+skid). occupancy = 0/1/2 accordingly.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (state != FULL), registered; never depends on out_ready in the same cycle.
- EMPTY: accept -> main := input, go ONE.
- ONE: accept & pop -> main := input, stay ONE. Accept only -> skid := input, go FULL. Pop only -> go EMPTY.
- FULL: pop -> main := skid, go ONE. No pop -> hold.
- Latency: an accepted entry appears on outputs the cycle after acceptance; throughput 1 per cycle when out_ready stays high.
- Ordering strictly FIFO; no entry is dropped or duplicated absent flush/reset.
- Outputs are driven from main-entry registers only (no input->output combinational path).
- Bubble masking: when out_valid=0, out_ctrl=0, so no regWrite/r0Write/memRead/memWrite reaches MEM. Data fields hold their last value and are don't-care.
- flush=1: next cycle state EMPTY, out_valid=0, in_ready=1, both valid bits cleared. A same-cycle accept is discarded. Flush beats accept and pop; the pop handshake that cycle still counts for MEM.
- reset=1: same as flush, and additionally all data/ctrl/rd registers := 0. Reset dominates flush. Reset mid-stall (FULL) fully empties the stage.
- Reset values: out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, out_rd=0, out_alu=out_store=out_r0=0.
- in_valid=0 with stale data in: nothing captured.

Decomposition:
- Shared package exmem_pkg: CTRL_W=5; bit indices CTRL_REGWRITE=0, CTRL_R0WRITE=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_MEMSOURCE=4; state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2; payload width constant.
- One sub-module: pipe_entry_reg (payload + valid register with load/clear), instantiated twice for main and skid.

Test Plan:
- Reset/idle: reset=1 for 2 cycles -> out_valid=0, out_ctrl=0, out_alu=0, in_ready=1, occupancy=0.
- Streaming: out_ready=1; push alu=0x0001..0x0004 on consecutive cycles, ctrl=5'b00001 -> outputs 0x0001..0x0004 one cycle later each, no gaps, occupancy stays 1.
- Backpressure: out_ready=0; push 0xAAAA, 0xBBBB -> occupancy=2, in_ready=0. Third push 0xCCCC held off. Release out_ready -> order 0xAAAA, 0xBBBB, 0xCCCC.
- Flush: FULL state, then flush=1 with in_valid=1 (alu=0x1234, ctrl=5'b01000) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x1234 never emerges.
- Bubble masking: after 0x00FF drains with out_ready=1 and in_valid=0 -> out_valid=0, out_ctrl=5'b00000 while out_alu may stay 0x00FF.
- Reset priority: FULL state, reset=1 and flush=1 in the same cycle -> all outputs 0, in_ready=1 next cycle. Push 0x0042 after reset -> appears 1 cycle later.
